// File: rtl/score_pkg.sv
// Shared score types used by score keeping, game control and the draw path.
// Digit nibbles are packed BCD so sprite lookup needs no divide.
package score_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RUN    = 2'd1,
      PAUSED = 2'd2,
      OVER   = 2'd3
   } game_state_t;

   typedef logic [3:0] bcd_digit_t;

   localparam bcd_digit_t BCD_MAX_DIGIT = 4'd9;

endpackage

// File: rtl/bcd_incrementer.sv
// Combinational +1 on a packed BCD number with ripple carry.
// low_zero[i] flags a digit that rolled from 9 to 0 on this increment.
module bcd_incrementer
   import score_pkg::*;
#(
   parameter int NUM_DIGITS = 5
) (
   input  logic [4*NUM_DIGITS-1:0] in_digits,
   output logic [4*NUM_DIGITS-1:0] out_digits,
   output logic                    carry_out,
   output logic [NUM_DIGITS-1:0]   low_zero
);

   logic [NUM_DIGITS:0] carry;

   assign carry[0] = 1'b1;

   for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_dig
      bcd_digit_t d;
      assign d = in_digits[4*i +: 4];
      assign low_zero[i] = carry[i] && (d == BCD_MAX_DIGIT);
      assign carry[i+1] = low_zero[i];
      assign out_digits[4*i +: 4] = !carry[i]   ? d :
                                    low_zero[i] ? 4'd0 :
                                                  d + 4'd1;
   end

   assign carry_out = carry[NUM_DIGITS];

endmodule

// File: rtl/score_keeper_bcd.sv
// Frame-driven BCD score keeper with game FSM, milestone pulse and high score.
// High score register/compare is present only when SCORE_HISCORE_EN is defined.
module score_keeper_bcd
   import score_pkg::*;
#(
   parameter int FRAMES_PER_POINT = 10,
   parameter int NUM_DIGITS       = 5,
   parameter int MILESTONE_DIGITS = 2
) (
   input  logic                    frame_Clk,
   input  logic                    Reset_n,
   input  logic                    start,
   input  logic                    pause,
   input  logic                    collide,
   output logic [4*NUM_DIGITS-1:0] score_digits,
   output logic [4*NUM_DIGITS-1:0] hi_digits,
   output game_state_t             game_state,
   output logic                    milestone,
   output logic                    new_hi
);

   localparam int FCW = $clog2(FRAMES_PER_POINT + 1);
   localparam logic [FCW-1:0] FC_ONE = FCW'(1);
   localparam logic [FCW-1:0] FC_MAX = FCW'(FRAMES_PER_POINT);

   logic [FCW-1:0]          frame_count;
   logic [4*NUM_DIGITS-1:0] score_inc;
   logic                    carry_out;
   logic [NUM_DIGITS-1:0]   low_zero;
   logic                    counting;
   logic                    point_due;
   logic                    ms_hit;
   logic                    restart;
   logic                    unused_lz;
   game_state_t             state_nxt;

   bcd_incrementer #(
      .NUM_DIGITS(NUM_DIGITS)
   ) u_inc (
      .in_digits (score_digits),
      .out_digits(score_inc),
      .carry_out (carry_out),
      .low_zero  (low_zero)
   );

   // collide and pause both suppress counting on their edge
   assign counting  = (game_state == RUN) && !collide && !pause;
   assign point_due = counting && (frame_count >= FC_MAX);
   assign ms_hit    = (&low_zero[MILESTONE_DIGITS-1:0]) | carry_out;
   assign restart   = start && ((game_state == IDLE) || (game_state == OVER));
   assign unused_lz = ^low_zero;

   always_comb begin
      state_nxt = game_state;
      unique case (game_state)
         IDLE:    if (start) state_nxt = RUN;
         RUN:     if (collide) state_nxt = OVER;
                  else if (pause) state_nxt = PAUSED;
         PAUSED:  if (collide) state_nxt = OVER;
                  else if (!pause) state_nxt = RUN;
         OVER:    if (start) state_nxt = RUN;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge frame_Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         game_state   <= IDLE;
         frame_count  <= FC_ONE;
         score_digits <= '0;
         milestone    <= 1'b0;
      end else begin
         game_state <= state_nxt;
         milestone  <= point_due && ms_hit;
         if (restart) begin
            score_digits <= '0;
            frame_count  <= FC_ONE;
         end else if (point_due) begin
            score_digits <= score_inc;
            frame_count  <= FC_ONE;
         end else if (counting) begin
            frame_count <= frame_count + FC_ONE;
         end
      end
   end

`ifdef SCORE_HISCORE_EN
   // score is frozen in OVER, so only the first OVER edge can win
   always_ff @(posedge frame_Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         hi_digits <= '0;
         new_hi    <= 1'b0;
      end else begin
         new_hi <= 1'b0;
         if ((game_state == OVER) && (score_digits > hi_digits)) begin
            hi_digits <= score_digits;
            new_hi    <= 1'b1;
         end
      end
   end
`else
   assign hi_digits = '0;
   assign new_hi    = 1'b0;
`endif

endmodule

// File: tb/tb_score_keeper_bcd.sv
// Self-checking bench for score_keeper_bcd against an integer-score model.
// Honours SCORE_HISCORE_EN when deciding expected high-score behaviour.
module tb_score_keeper_bcd;
   import score_pkg::*;

   localparam int FPP   = 10;
   localparam int ND    = 5;
   localparam int MAXS  = 100000;
   localparam int MSMOD = 100;
`ifdef SCORE_HISCORE_EN
   localparam bit HI_EN = 1'b1;
`else
   localparam bit HI_EN = 1'b0;
`endif

   logic        frame_Clk = 1'b0;
   logic        Reset_n   = 1'b0;
   logic        start     = 1'b0;
   logic        pause     = 1'b0;
   logic        collide   = 1'b0;
   logic [19:0] score_digits;
   logic [19:0] hi_digits;
   game_state_t game_state;
   logic        milestone;
   logic        new_hi;

   logic        s_start = 1'b0;
   logic [7:0]  s_score;
   logic [7:0]  s_hi;
   game_state_t s_state;
   logic        s_ms;
   logic        s_nh;

   int n_tests = 0;
   int n_fail  = 0;

   int m_state;
   int m_score;
   int m_hi;
   int m_fc;
   bit m_ms;
   bit m_nh;

   always #5 frame_Clk = ~frame_Clk;

   score_keeper_bcd #(
      .FRAMES_PER_POINT(FPP),
      .NUM_DIGITS      (ND),
      .MILESTONE_DIGITS(2)
   ) dut (
      .frame_Clk   (frame_Clk),
      .Reset_n     (Reset_n),
      .start       (start),
      .pause       (pause),
      .collide     (collide),
      .score_digits(score_digits),
      .hi_digits   (hi_digits),
      .game_state  (game_state),
      .milestone   (milestone),
      .new_hi      (new_hi)
   );

   score_keeper_bcd #(
      .FRAMES_PER_POINT(1),
      .NUM_DIGITS      (2),
      .MILESTONE_DIGITS(2)
   ) u_small (
      .frame_Clk   (frame_Clk),
      .Reset_n     (Reset_n),
      .start       (s_start),
      .pause       (1'b0),
      .collide     (1'b0),
      .score_digits(s_score),
      .hi_digits   (s_hi),
      .game_state  (s_state),
      .milestone   (s_ms),
      .new_hi      (s_nh)
   );

   function automatic logic [19:0] to_bcd(input int v);
      logic [19:0] r;
      int x;
      r = '0;
      x = v;
      for (int i = 0; i < ND; i++) begin
         r[4*i +: 4] = 4'(x % 10);
         x = x / 10;
      end
      return r;
   endfunction

   task automatic model_reset();
      m_state = 0;
      m_score = 0;
      m_hi    = 0;
      m_fc    = 1;
      m_ms    = 1'b0;
      m_nh    = 1'b0;
   endtask

   task automatic model_edge(input bit st, input bit ps, input bit co);
      m_ms = 1'b0;
      m_nh = 1'b0;
      case (m_state)
         0: if (st) begin m_state = 1; m_score = 0; m_fc = 1; end
         1: begin
            if (co) m_state = 3;
            else if (ps) m_state = 2;
            else if (m_fc < FPP) m_fc = m_fc + 1;
            else begin
               m_fc    = 1;
               m_score = (m_score + 1) % MAXS;
               m_ms    = (m_score % MSMOD) == 0;
            end
         end
         2: begin
            if (co) m_state = 3;
            else if (!ps) m_state = 1;
         end
         default: begin
            if (HI_EN && (m_score > m_hi)) begin
               m_hi = m_score;
               m_nh = 1'b1;
            end
            if (st) begin m_state = 1; m_score = 0; m_fc = 1; end
         end
      endcase
   endtask

   task automatic step(input bit st, input bit ps, input bit co);
      start   = st;
      pause   = ps;
      collide = co;
      @(posedge frame_Clk);
      model_edge(st, ps, co);
      #1;
      start   = 1'b0;
      collide = 1'b0;
   endtask

   task automatic apply_reset();
      #2;
      Reset_n = 1'b0;
      model_reset();
      #2;
      Reset_n = 1'b1;
      pause   = 1'b0;
   endtask

   task automatic run_to(input int target);
      int n;
      n = 0;
      while (!(m_state == 1 && m_score == target) && n < 20000) begin
         step(1'b0, 1'b0, 1'b0);
         n++;
      end
      if (n >= 20000) begin
         n_tests++;
         n_fail++;
         $display("FAIL run_to: score %0d never reached", target);
      end
   endtask

   task automatic test_reset();
      model_reset();
      #12;
      n_tests += 6;
      if (score_digits !== 20'h0) begin n_fail++; $display("FAIL rst_score: got %h want 00000", score_digits); end
      if (hi_digits !== 20'h0) begin n_fail++; $display("FAIL rst_hi: got %h want 00000", hi_digits); end
      if (game_state !== IDLE) begin n_fail++; $display("FAIL rst_state: got %0d want 0", game_state); end
      if (milestone !== 1'b0) begin n_fail++; $display("FAIL rst_ms: got %b want 0", milestone); end
      if (new_hi !== 1'b0) begin n_fail++; $display("FAIL rst_nh: got %b want 0", new_hi); end
      if (s_score !== 8'h0) begin n_fail++; $display("FAIL rst_small: got %h want 00", s_score); end
      Reset_n = 1'b1;
   endtask

   task automatic test_count();
      step(1'b1, 1'b0, 1'b0);
      for (int e = 1; e <= 30; e++) begin
         step(1'b0, 1'b0, 1'b0);
         if (e == 9) begin
            n_tests++;
            if (score_digits !== 20'h00000) begin n_fail++; $display("FAIL cnt_e9: got %h want 00000", score_digits); end
         end
         if (e == 10) begin
            n_tests++;
            if (score_digits !== 20'h00001) begin n_fail++; $display("FAIL cnt_e10: got %h want 00001", score_digits); end
         end
      end
      n_tests += 2;
      if (score_digits !== 20'h00003) begin n_fail++; $display("FAIL cnt_e30: got %h want 00003", score_digits); end
      if (game_state !== RUN) begin n_fail++; $display("FAIL cnt_state: got %0d want 1", game_state); end
   endtask

   task automatic test_milestone();
      int n;
      run_to(99);
      n_tests++;
      if (milestone !== 1'b0) begin n_fail++; $display("FAIL ms_early: got %b want 0", milestone); end
      n = 0;
      while (score_digits !== 20'h00100 && n < 20) begin
         step(1'b0, 1'b0, 1'b0);
         n++;
      end
      n_tests += 2;
      if (score_digits !== 20'h00100) begin n_fail++; $display("FAIL ms_score: got %h want 00100", score_digits); end
      if (milestone !== 1'b1) begin n_fail++; $display("FAIL ms_pulse: got %b want 1", milestone); end
      step(1'b0, 1'b0, 1'b0);
      n_tests++;
      if (milestone !== 1'b0) begin n_fail++; $display("FAIL ms_width: got %b want 0", milestone); end
   endtask

   task automatic test_pause();
      int f;
      int n;
      int exp_n;
      run_to(250);
      for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0);
      f = m_fc;
      for (int i = 0; i < 50; i++) step(1'b0, 1'b1, 1'b0);
      n_tests += 2;
      if (score_digits !== 20'h00250) begin n_fail++; $display("FAIL pause_score: got %h want 00250", score_digits); end
      if (game_state !== PAUSED) begin n_fail++; $display("FAIL pause_state: got %0d want 2", game_state); end
      step(1'b0, 1'b0, 1'b0);
      n_tests++;
      if (game_state !== RUN) begin n_fail++; $display("FAIL unpause_state: got %0d want 1", game_state); end
      exp_n = FPP - f + 1;
      n = 0;
      while (score_digits === 20'h00250 && n < 30) begin
         step(1'b0, 1'b0, 1'b0);
         n++;
      end
      n_tests++;
      if (n != exp_n) begin n_fail++; $display("FAIL resume_edges: got %0d want %0d", n, exp_n); end
   endtask

   task automatic test_collide_priority();
      int n;
      int sc;
      n = 0;
      while (m_fc != FPP && n < 20) begin
         step(1'b0, 1'b0, 1'b0);
         n++;
      end
      sc = m_score;
      step(1'b0, 1'b1, 1'b1);
      n_tests += 2;
      if (game_state !== OVER) begin n_fail++; $display("FAIL col_state: got %0d want 3", game_state); end
      if (score_digits !== to_bcd(sc)) begin n_fail++; $display("FAIL col_frozen: got %h want %h", score_digits, to_bcd(sc)); end
      step(1'b0, 1'b0, 1'b0);
      n_tests += 2;
      if (hi_digits !== (HI_EN ? to_bcd(sc) : 20'h0)) begin n_fail++; $display("FAIL col_hi: got %h want %h", hi_digits, HI_EN ? to_bcd(sc) : 20'h0); end
      if (new_hi !== HI_EN) begin n_fail++; $display("FAIL col_nh: got %b want %b", new_hi, HI_EN); end
   endtask

   task automatic test_hiscore();
      logic [19:0] exp_hi;
      exp_hi = HI_EN ? 20'h00120 : 20'h0;
      apply_reset();
      step(1'b1, 1'b0, 1'b0);
      run_to(120);
      step(1'b0, 1'b0, 1'b1);
      n_tests += 2;
      if (game_state !== OVER) begin n_fail++; $display("FAIL g1_state: got %0d want 3", game_state); end
      if (new_hi !== 1'b0) begin n_fail++; $display("FAIL g1_nh_early: got %b want 0", new_hi); end
      step(1'b0, 1'b0, 1'b0);
      n_tests += 2;
      if (hi_digits !== exp_hi) begin n_fail++; $display("FAIL g1_hi: got %h want %h", hi_digits, exp_hi); end
      if (new_hi !== HI_EN) begin n_fail++; $display("FAIL g1_nh: got %b want %b", new_hi, HI_EN); end
      step(1'b0, 1'b0, 1'b0);
      n_tests++;
      if (new_hi !== 1'b0) begin n_fail++; $display("FAIL g1_nh_width: got %b want 0", new_hi); end
      step(1'b1, 1'b0, 1'b0);
      n_tests += 3;
      if (score_digits !== 20'h0) begin n_fail++; $display("FAIL g2_clear: got %h want 00000", score_digits); end
      if (game_state !== RUN) begin n_fail++; $display("FAIL g2_state: got %0d want 1", game_state); end
      if (hi_digits !== exp_hi) begin n_fail++; $display("FAIL g2_hi_kept: got %h want %h", hi_digits, exp_hi); end
      run_to(80);
      step(1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 2; i++) begin
         step(1'b0, 1'b0, 1'b0);
         n_tests += 2;
         if (hi_digits !== exp_hi) begin n_fail++; $display("FAIL g2_hi: got %h want %h", hi_digits, exp_hi); end
         if (new_hi !== 1'b0) begin n_fail++; $display("FAIL g2_nh: got %b want 0", new_hi); end
      end
   endtask

   task automatic test_async_reset();
      step(1'b1, 1'b0, 1'b0);
      run_to(42);
      n_tests++;
      if (score_digits !== 20'h00042) begin n_fail++; $display("FAIL ar_pre: got %h want 00042", score_digits); end
      #2;
      Reset_n = 1'b0;
      #1;
      n_tests += 5;
      if (score_digits !== 20'h0) begin n_fail++; $display("FAIL ar_score: got %h want 00000", score_digits); end
      if (hi_digits !== 20'h0) begin n_fail++; $display("FAIL ar_hi: got %h want 00000", hi_digits); end
      if (game_state !== IDLE) begin n_fail++; $display("FAIL ar_state: got %0d want 0", game_state); end
      if (milestone !== 1'b0) begin n_fail++; $display("FAIL ar_ms: got %b want 0", milestone); end
      if (new_hi !== 1'b0) begin n_fail++; $display("FAIL ar_nh: got %b want 0", new_hi); end
      model_reset();
      #2;
      Reset_n = 1'b1;
   endtask

   task automatic test_wrap();
      s_start = 1'b1;
      @(posedge frame_Clk);
      #1;
      s_start = 1'b0;
      for (int i = 0; i < 99; i++) begin
         @(posedge frame_Clk);
         #1;
      end
      n_tests += 2;
      if (s_score !== 8'h99) begin n_fail++; $display("FAIL wrap_pre: got %h want 99", s_score); end
      if (s_ms !== 1'b0) begin n_fail++; $display("FAIL wrap_ms_pre: got %b want 0", s_ms); end
      @(posedge frame_Clk);
      #1;
      n_tests += 3;
      if (s_score !== 8'h00) begin n_fail++; $display("FAIL wrap_score: got %h want 00", s_score); end
      if (s_ms !== 1'b1) begin n_fail++; $display("FAIL wrap_ms: got %b want 1", s_ms); end
      if (s_state !== RUN) begin n_fail++; $display("FAIL wrap_state: got %0d want 1", s_state); end
      @(posedge frame_Clk);
      #1;
      n_tests += 2;
      if (s_ms !== 1'b0) begin n_fail++; $display("FAIL wrap_ms_width: got %b want 0", s_ms); end
      if (s_score !== 8'h01) begin n_fail++; $display("FAIL wrap_next: got %h want 01", s_score); end
   endtask

   task automatic test_random();
      bit st;
      bit co;
      bit rp;
      logic [19:0] exp_sc;
      logic [19:0] exp_hi;
      rp = 1'b0;
      apply_reset();
      for (int i = 0; i < 3000; i++) begin
         st = $urandom_range(0, 99) < 3;
         co = $urandom_range(0, 99) < 1;
         if ($urandom_range(0, 99) < 4) rp = ~rp;
         step(st, rp, co);
         exp_sc = to_bcd(m_score);
         exp_hi = to_bcd(m_hi);
         n_tests++;
         if (score_digits !== exp_sc || hi_digits !== exp_hi ||
             2'(game_state) !== 2'(m_state) ||
             milestone !== m_ms || new_hi !== m_nh) begin
            n_fail++;
            if (n_fail < 20)
               $display("FAIL rand_%0d: got sc=%h hi=%h st=%0d ms=%b nh=%b want sc=%h hi=%h st=%0d ms=%b nh=%b",
                        i, score_digits, hi_digits, game_state, milestone, new_hi,
                        exp_sc, exp_hi, m_state, m_ms, m_nh);
         end
      end
   endtask

   initial begin
      test_reset();
      test_count();
      test_milestone();
      test_pause();
      test_collide_priority();
      test_hiscore();
      test_async_reset();
      test_wrap();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
